// File: rtl/flt_cfg_cmd_initiator.sv
// Host-side initiator for the FLT configuration command bus: one request at a time,
// split into single-cycle wr/rd beats, with read-response matching and a timeout.
module flt_cfg_cmd_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_wr,
   input  logic        i_req_entry,
   input  logic [18:0] iv_req_addr,
   input  logic        i_req_addr_fixed,
   input  logic [56:0] iv_req_wdata,
   output logic        o_rsp_valid,
   output logic [56:0] ov_rsp_rdata,
   output logic        o_rsp_err,
   output logic        o_wr,
   output logic        o_rd,
   output logic [18:0] ov_addr,
   output logic        o_addr_fixed,
   output logic [31:0] ov_wdata,
   input  logic        i_wr,
   input  logic [18:0] iv_addr,
   input  logic        i_addr_fixed,
   input  logic [31:0] iv_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

   // Entry beats use the even/odd word pair and never the fixed-address flag.
   function automatic logic [18:0] beat_addr(input logic [18:0] addr, input logic entry,
                                             input logic beat);
      return entry ? {addr[18:1], beat} : addr;
   endfunction

   function automatic logic beat_fixed(input logic fixed, input logic entry);
      return entry ? 1'b0 : fixed;
   endfunction

   function automatic logic [31:0] beat_wdata(input logic [56:0] wdata, input logic entry,
                                              input logic beat);
      logic [31:0] word;
      if (entry && !beat) begin
         word = {7'd0, wdata[56:32]};
      end else begin
         word = wdata[31:0];
      end
      return word;
   endfunction

   state_t      state_r, state_s;
   logic        beat_r, beat_s;
   logic [7:0]  cnt_r, cnt_s;
   logic [24:0] hi_r, hi_s;
   logic [31:0] lo_r, lo_s;
   logic        err_r, err_s;
   logic        req_wr_r, req_entry_r, req_fixed_r;
   logic [18:0] req_addr_r;
   logic [56:0] req_wdata_r;
   logic        latch_s, match_s;
   logic        bus_wr_s, bus_rd_s, bus_fixed_s;
   logic [18:0] bus_addr_s;
   logic [31:0] bus_wdata_s;

   // Next-state, capture and next bus-beat decode.
   always_comb begin
      state_s     = state_r;
      beat_s      = beat_r;
      cnt_s       = cnt_r;
      hi_s        = hi_r;
      lo_s        = lo_r;
      err_s       = err_r;
      latch_s     = 1'b0;
      bus_wr_s    = 1'b0;
      bus_rd_s    = 1'b0;
      bus_addr_s  = 19'd0;
      bus_fixed_s = 1'b0;
      bus_wdata_s = 32'd0;
      match_s     = i_wr && (iv_addr == beat_addr(req_addr_r, req_entry_r, beat_r)) &&
                    (i_addr_fixed == beat_fixed(req_fixed_r, req_entry_r));
      case (state_r)
         ST_IDLE: begin
            if (i_req_valid && o_req_ready) begin
               latch_s     = 1'b1;
               beat_s      = 1'b0;
               hi_s        = 25'd0;
               lo_s        = 32'd0;
               err_s       = 1'b0;
               state_s     = ST_ISSUE;
               bus_wr_s    = i_req_wr;
               bus_rd_s    = !i_req_wr;
               bus_addr_s  = beat_addr(iv_req_addr, i_req_entry, 1'b0);
               bus_fixed_s = beat_fixed(i_req_addr_fixed, i_req_entry);
               bus_wdata_s = i_req_wr ? beat_wdata(iv_req_wdata, i_req_entry, 1'b0) : 32'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_s = 8'd0;
            if (!req_wr_r) begin
               state_s = ST_WAIT;
            end else if (req_entry_r && !beat_r) begin
               // Second write beat follows immediately, no gap cycle.
               beat_s      = 1'b1;
               state_s     = ST_ISSUE;
               bus_wr_s    = 1'b1;
               bus_addr_s  = beat_addr(req_addr_r, 1'b1, 1'b1);
               bus_wdata_s = beat_wdata(req_wdata_r, 1'b1, 1'b1);
            end else begin
               state_s = ST_RESP;
            end
         end
         ST_WAIT: begin
            cnt_s = cnt_r + 8'd1;
            if (match_s) begin
               if (req_entry_r && !beat_r) begin
                  hi_s       = iv_rdata[24:0];
                  beat_s     = 1'b1;
                  state_s    = ST_ISSUE;
                  bus_rd_s   = 1'b1;
                  bus_addr_s = beat_addr(req_addr_r, 1'b1, 1'b1);
               end else begin
                  lo_s    = iv_rdata;
                  state_s = ST_RESP;
               end
            end else if (cnt_s == TMO_LIMIT) begin
               err_s   = 1'b1;
               state_s = ST_RESP;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, request latch and registered outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r      <= ST_IDLE;
         beat_r       <= 1'b0;
         cnt_r        <= 8'd0;
         hi_r         <= 25'd0;
         lo_r         <= 32'd0;
         err_r        <= 1'b0;
         req_wr_r     <= 1'b0;
         req_entry_r  <= 1'b0;
         req_fixed_r  <= 1'b0;
         req_addr_r   <= 19'd0;
         req_wdata_r  <= 57'd0;
         o_req_ready  <= 1'b0;
         o_rsp_valid  <= 1'b0;
         o_rsp_err    <= 1'b0;
         ov_rsp_rdata <= 57'd0;
         o_wr         <= 1'b0;
         o_rd         <= 1'b0;
         ov_addr      <= 19'd0;
         o_addr_fixed <= 1'b0;
         ov_wdata     <= 32'd0;
      end else begin
         state_r <= state_s;
         beat_r  <= beat_s;
         cnt_r   <= cnt_s;
         hi_r    <= hi_s;
         lo_r    <= lo_s;
         err_r   <= err_s;
         if (latch_s) begin
            req_wr_r    <= i_req_wr;
            req_entry_r <= i_req_entry;
            req_fixed_r <= i_req_addr_fixed;
            req_addr_r  <= iv_req_addr;
            req_wdata_r <= iv_req_wdata;
         end else begin
            req_wr_r    <= req_wr_r;
            req_entry_r <= req_entry_r;
            req_fixed_r <= req_fixed_r;
            req_addr_r  <= req_addr_r;
            req_wdata_r <= req_wdata_r;
         end
         o_req_ready  <= (state_s == ST_IDLE);
         o_rsp_valid  <= (state_s == ST_RESP);
         o_rsp_err    <= (state_s == ST_RESP) && err_s;
         ov_rsp_rdata <= ((state_s == ST_RESP) && !req_wr_r && !err_s) ? {hi_s, lo_s} : 57'd0;
         o_wr         <= bus_wr_s;
         o_rd         <= bus_rd_s;
         ov_addr      <= bus_addr_s;
         o_addr_fixed <= bus_fixed_s;
         ov_wdata     <= bus_wdata_s;
      end
   end

endmodule

// File: tb/tb_flt_cfg_cmd_initiator.sv
// Directed self-checking bench for flt_cfg_cmd_initiator; the bus responder is
// driven inline by the test sequence with hand-computed expected values.
module tb_flt_cfg_cmd_initiator;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_req_valid, o_req_ready, i_req_wr, i_req_entry, i_req_addr_fixed;
   logic [18:0] iv_req_addr;
   logic [56:0] iv_req_wdata;
   logic        o_rsp_valid, o_rsp_err;
   logic [56:0] ov_rsp_rdata;
   logic        o_wr, o_rd, o_addr_fixed;
   logic [18:0] ov_addr;
   logic [31:0] ov_wdata;
   logic        i_wr, i_addr_fixed;
   logic [18:0] iv_addr;
   logic [31:0] iv_rdata;

   int n_checks = 0;
   int n_errors = 0;

   flt_cfg_cmd_initiator #(.TIMEOUT_CYCLES(15)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
      .i_req_entry(i_req_entry), .iv_req_addr(iv_req_addr),
      .i_req_addr_fixed(i_req_addr_fixed), .iv_req_wdata(iv_req_wdata),
      .o_rsp_valid(o_rsp_valid), .ov_rsp_rdata(ov_rsp_rdata), .o_rsp_err(o_rsp_err),
      .o_wr(o_wr), .o_rd(o_rd), .ov_addr(ov_addr), .o_addr_fixed(o_addr_fixed),
      .ov_wdata(ov_wdata), .i_wr(i_wr), .iv_addr(iv_addr), .i_addr_fixed(i_addr_fixed),
      .iv_rdata(iv_rdata)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge; outputs are stable there.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_req(input logic wr, input logic entry, input logic [18:0] addr,
                           input logic fixed, input logic [56:0] wdata);
      chk("ready_before_req", 64'(o_req_ready), 64'd1);
      i_req_valid = 1'b1; i_req_wr = wr; i_req_entry = entry;
      iv_req_addr = addr; i_req_addr_fixed = fixed; iv_req_wdata = wdata;
      tick();
      i_req_valid = 1'b0;
   endtask

   // Wait n cycles, present one response beat for a single cycle, then release it.
   task automatic respond(input int n, input logic [18:0] a, input logic f,
                          input logic [31:0] d);
      repeat (n) tick();
      i_wr = 1'b1; iv_addr = a; i_addr_fixed = f; iv_rdata = d;
      tick();
      i_wr = 1'b0; iv_addr = 19'd0; i_addr_fixed = 1'b0; iv_rdata = 32'd0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_flags"}, 64'({o_req_ready, o_rsp_valid, o_rsp_err, o_wr, o_rd, o_addr_fixed}),
          64'd0);
      chk({tag, "_addr"}, 64'(ov_addr), 64'd0);
      chk({tag, "_wdata"}, 64'(ov_wdata), 64'd0);
      chk({tag, "_rdata"}, 64'(ov_rsp_rdata), 64'd0);
   endtask

   initial begin
      int n;
      i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_entry = 1'b0;
      iv_req_addr = 19'd0; i_req_addr_fixed = 1'b0; iv_req_wdata = 57'd0;
      i_wr = 1'b0; iv_addr = 19'd0; i_addr_fixed = 1'b0; iv_rdata = 32'd0;
      repeat (3) tick();
      chk_all_zero("reset");
      i_rst_n = 1'b1;
      tick();
      chk("ready_after_reset", 64'(o_req_ready), 64'd1);

      // Single write
      send_req(1'b1, 1'b0, 19'h00123, 1'b1, 57'h1A5);
      chk("sw_wr", 64'({o_wr, o_rd}), 64'h2);
      chk("sw_addr", 64'(ov_addr), 64'h00123);
      chk("sw_wdata", 64'(ov_wdata), 64'h1A5);
      chk("sw_fixed", 64'(o_addr_fixed), 64'd1);
      chk("sw_ready_low", 64'(o_req_ready), 64'd0);
      tick();
      chk("sw_rsp", 64'({o_rsp_valid, o_rsp_err, o_wr}), 64'h4);
      chk("sw_rdata", 64'(ov_rsp_rdata), 64'd0);
      tick();
      chk("sw_idle", 64'({o_req_ready, o_rsp_valid}), 64'h2);

      // Entry write: fixed flag in the request must be forced to 0 on the bus
      send_req(1'b1, 1'b1, 19'h04005, 1'b1, 57'h1_2345_6789_ABCD);
      chk("ew_b0", 64'({o_wr, o_rd, o_addr_fixed}), 64'h4);
      chk("ew_b0_addr", 64'(ov_addr), 64'h04004);
      chk("ew_b0_wdata", 64'(ov_wdata), 64'h00012345);
      tick();
      chk("ew_b1", 64'({o_wr, o_rd, o_addr_fixed}), 64'h4);
      chk("ew_b1_addr", 64'(ov_addr), 64'h04005);
      chk("ew_b1_wdata", 64'(ov_wdata), 64'h6789ABCD);
      tick();
      chk("ew_rsp", 64'({o_rsp_valid, o_rsp_err, o_wr}), 64'h4);
      tick();

      // Entry read, 5-cycle responder; upper bits of beat 0 must be dropped
      send_req(1'b0, 1'b1, 19'h00A31, 1'b1, 57'd0);
      chk("er_b0", 64'({o_wr, o_rd, o_addr_fixed}), 64'h2);
      chk("er_b0_addr", 64'(ov_addr), 64'h00A30);
      respond(5, 19'h00A30, 1'b0, 32'hFE01_2345);
      chk("er_b1", 64'({o_rd, o_rsp_valid}), 64'h2);
      chk("er_b1_addr", 64'(ov_addr), 64'h00A31);
      respond(5, 19'h00A31, 1'b0, 32'h6789_ABCD);
      chk("er_rsp", 64'({o_rsp_valid, o_rsp_err}), 64'h2);
      chk("er_rdata", 64'(ov_rsp_rdata), 64'h1_2345_6789_ABCD);
      tick();

      // Silent responder: timeout 15 WAIT cycles, rsp at T+17 (16 ticks after T+1)
      send_req(1'b0, 1'b0, 19'h00077, 1'b0, 57'd0);
      chk("to_rd", 64'(o_rd), 64'd1);
      n = 0;
      while (!o_rsp_valid && n < 40) begin
         tick();
         n++;
         if (n == 1) chk("to_wait_strobes", 64'({o_wr, o_rd}), 64'd0);
      end
      chk("to_latency", 64'(n), 64'd16);
      chk("to_err", 64'({o_rsp_valid, o_rsp_err}), 64'h3);
      chk("to_rdata", 64'(ov_rsp_rdata), 64'd0);
      tick();
      send_req(1'b1, 1'b0, 19'h00042, 1'b0, 57'h55);
      chk("to_next_wr", 64'({o_wr, ov_addr}), {44'd0, 1'b1, 19'h00042});
      tick();
      chk("to_next_rsp", 64'({o_rsp_valid, o_rsp_err}), 64'h2);
      tick();

      // Non-matching responses (wrong addr, then wrong flag) are ignored
      send_req(1'b0, 1'b0, 19'h00200, 1'b1, 57'd0);
      respond(2, 19'h00201, 1'b1, 32'hDEAD_0001);
      chk("nm_addr_ignored", 64'(o_rsp_valid), 64'd0);
      respond(0, 19'h00200, 1'b0, 32'hDEAD_0002);
      chk("nm_flag_ignored", 64'(o_rsp_valid), 64'd0);
      respond(0, 19'h00200, 1'b1, 32'h0BAD_F00D);
      chk("nm_rsp", 64'({o_rsp_valid, o_rsp_err}), 64'h2);
      chk("nm_rdata", 64'(ov_rsp_rdata), 64'h0BAD_F00D);
      tick();

      // Match on the last WAIT cycle wins over the timeout
      send_req(1'b0, 1'b0, 19'h00300, 1'b0, 57'd0);
      respond(15, 19'h00300, 1'b0, 32'h1357_2468);
      chk("edge_rsp", 64'({o_rsp_valid, o_rsp_err}), 64'h2);
      chk("edge_rdata", 64'(ov_rsp_rdata), 64'h1357_2468);
      tick();

      // Reset during WAIT of an entry read
      send_req(1'b0, 1'b1, 19'h01001, 1'b0, 57'd0);
      repeat (3) tick();
      i_rst_n = 1'b0;
      i_wr = 1'b1; iv_addr = 19'h01000; iv_rdata = 32'h0000_0ABC;
      tick();
      chk_all_zero("rst_wait");
      i_wr = 1'b0; iv_addr = 19'd0; iv_rdata = 32'd0;
      tick();
      i_rst_n = 1'b1;
      tick();
      chk("rst_ready", 64'({o_req_ready, o_rsp_valid}), 64'h2);
      n = 0;
      repeat (20) begin
         tick();
         if (o_rsp_valid || o_rd || o_wr) n++;
      end
      chk("rst_no_activity", 64'(n), 64'd0);

      // Single read against the 5-cycle responder completes at T+7
      send_req(1'b0, 1'b0, 19'h7FFFF, 1'b1, 57'd0);
      chk("sr_rd_addr", 64'({o_rd, o_addr_fixed, ov_addr}), {43'd0, 2'b11, 19'h7FFFF});
      respond(5, 19'h7FFFF, 1'b1, 32'hCAFE_BABE);
      chk("sr_rsp", 64'({o_rsp_valid, o_rsp_err}), 64'h2);
      chk("sr_rdata", 64'(ov_rsp_rdata), 64'h0_0000_CAFE_BABE);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
